// File: rtl/imem_responder_if.sv
// Fetch-port and program-loader signal bundle for imem_responder.
// AW must equal $clog2(DEPTH_WORDS) of the responder it is connected to.
interface imem_responder_if #(
  parameter int AW = 10
);
  logic        read_i;
  logic [31:0] raddr_i;
  logic [31:0] rdata_o;
  logic        load_start_i;
  logic [AW:0] load_words_i;
  logic        load_byte_valid_i;
  logic [7:0]  load_byte_i;
  logic        load_busy_o;
  logic        load_done_o;
  logic        err_o;

  modport master (
    output read_i, raddr_i, load_start_i, load_words_i, load_byte_valid_i, load_byte_i,
    input  rdata_o, load_busy_o, load_done_o, err_o
  );

  modport slave (
    input  read_i, raddr_i, load_start_i, load_words_i, load_byte_valid_i, load_byte_i,
    output rdata_o, load_busy_o, load_done_o, err_o
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory with a 1-cycle fetch port and a byte-serial little-endian program loader.
// Define IMEM_ADDR_ERR_EN to flag misaligned/out-of-range fetches on err_o.
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  imem_responder_if.slave          bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] word_ptr;
  logic [AW-1:0] last_ptr;
  logic [1:0]    byte_cnt;
  logic [23:0]   byte_buf;
  logic          wr_en;
  logic          busy;
  logic          done;

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          addr_err;
  logic [31:0]   rdata;

  assign offset = bus.raddr_i - BASE_ADDR;
  assign idx    = offset[AW+1:2];

`ifdef IMEM_ADDR_ERR_EN
  // 33-bit limit so a window ending at the top of the address space cannot overflow.
  localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  logic err;

  assign addr_err = (bus.raddr_i[1:0] != 2'b00)
                 || (bus.raddr_i < BASE_ADDR)
                 || ({1'b0, bus.raddr_i} >= ADDR_LIMIT);
  assign bus.err_o = err;
`else
  assign addr_err  = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

  assign wr_en = (state == LOAD) && bus.load_byte_valid_i && (byte_cnt == 2'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_start_i) begin
          state_next = (bus.load_words_i != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (wr_en && (word_ptr == last_ptr)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.load_busy_o = busy;
  assign bus.load_done_o = done;

  // Loader datapath; last_ptr holds n-1 so a clamped full-depth load still fits in AW bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_ptr <= '0;
      last_ptr <= '0;
      byte_cnt <= 2'd0;
      byte_buf <= '0;
    end else begin
      if (state == IDLE && bus.load_start_i) begin
        word_ptr <= '0;
        byte_cnt <= 2'd0;
        if (bus.load_words_i >= DEPTH_W) begin
          last_ptr <= LAST_IDX;
        end else if (bus.load_words_i != '0) begin
          last_ptr <= AW'(bus.load_words_i - 1'b1);
        end
      end else if (state == LOAD && bus.load_byte_valid_i) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: byte_buf[7:0]   <= bus.load_byte_i;
          2'd1: byte_buf[15:8]  <= bus.load_byte_i;
          2'd2: byte_buf[23:16] <= bus.load_byte_i;
          default: begin
            if (word_ptr != last_ptr) begin
              word_ptr <= word_ptr + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[word_ptr] <= {bus.load_byte_i, byte_buf};
    end
  end

  // Fetch port: the array is only visible to the core while the loader is idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata <= NOP_INSTR;
    end else if (bus.read_i) begin
      if (addr_err || (state != IDLE)) begin
        rdata <= NOP_INSTR;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

`ifdef IMEM_ADDR_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err <= 1'b0;
    end else if (bus.read_i) begin
      err <= addr_err;
    end
  end
`endif

  assign bus.rdata_o = rdata;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: reset, loads, clamping, mid-load reset and fetch reads.
// Expectations for out-of-window reads follow the IMEM_ADDR_ERR_EN setting of the build.
module tb_imem_responder;

  localparam int          DEPTH = 16;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst;
  int   vector_count;
  int   miss_count;

  imem_responder_if #(.AW(AW)) bus ();

  imem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (32'h0000_0000),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bus.load_byte_valid_i = 1'b1;
    bus.load_byte_i       = b;
    tick();
    bus.load_byte_valid_i = 1'b0;
  endtask

  task automatic start_load(input logic [AW:0] n);
    bus.load_start_i = 1'b1;
    bus.load_words_i = n;
    tick();
    bus.load_start_i = 1'b0;
  endtask

  task automatic read_word(input logic [31:0] addr, input string tag, input logic [31:0] expected);
    bus.read_i  = 1'b1;
    bus.raddr_i = addr;
    tick();
    bus.read_i  = 1'b0;
    checkOutput(tag, bus.rdata_o, expected);
  endtask

  initial begin
    logic [7:0] prog [8];
    logic [31:0] hold_val;
    prog = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    vector_count = 0;
    miss_count   = 0;

    rst                   = 1'b1;
    bus.read_i            = 1'b1;
    bus.raddr_i           = 32'h0;
    bus.load_start_i      = 1'b0;
    bus.load_words_i      = '0;
    bus.load_byte_valid_i = 1'b0;
    bus.load_byte_i       = 8'h00;
    tick();
    tick();
    checkOutput("reset_rdata", bus.rdata_o, NOP);
    checkOutput("reset_busy", 32'(bus.load_busy_o), 32'd0);
    checkOutput("reset_done", 32'(bus.load_done_o), 32'd0);
    checkOutput("reset_err", 32'(bus.err_o), 32'd0);
    bus.read_i = 1'b0;
    rst = 1'b0;
    tick();

    $display("[TB] two-word load");
    start_load(5'd2);
    checkOutput("load_busy", 32'(bus.load_busy_o), 32'd1);
    read_word(32'h0, "read_during_load", NOP);
    for (int i = 0; i < 7; i++) applyStimulus(prog[i]);
    bus.read_i  = 1'b1;
    bus.raddr_i = 32'h0;
    applyStimulus(prog[7]);
    bus.read_i  = 1'b0;
    checkOutput("read_final_write", bus.rdata_o, NOP);
    checkOutput("done_pulse", 32'(bus.load_done_o), 32'd1);
    checkOutput("busy_after_load", 32'(bus.load_busy_o), 32'd0);
    tick();
    checkOutput("done_cleared", 32'(bus.load_done_o), 32'd0);
    read_word(32'h0, "word0", 32'h00A0_0513);
    checkOutput("word0_err", 32'(bus.err_o), 32'd0);
    read_word(32'h4, "word1", 32'h00B0_0593);

    $display("[TB] back-to-back reads");
    bus.read_i  = 1'b1;
    bus.raddr_i = 32'h0;
    tick();
    checkOutput("b2b_0", bus.rdata_o, 32'h00A0_0513);
    bus.raddr_i = 32'h4;
    tick();
    checkOutput("b2b_1", bus.rdata_o, 32'h00B0_0593);
    bus.raddr_i = 32'h0;
    tick();
    checkOutput("b2b_2", bus.rdata_o, 32'h00A0_0513);
    bus.read_i  = 1'b0;
    bus.raddr_i = 32'h4;
    tick();
    checkOutput("hold_rdata", bus.rdata_o, 32'h00A0_0513);

    $display("[TB] zero-length load");
    start_load(5'd0);
    checkOutput("zero_done", 32'(bus.load_done_o), 32'd1);
    checkOutput("zero_busy", 32'(bus.load_busy_o), 32'd0);
    tick();
    checkOutput("zero_done_clr", 32'(bus.load_done_o), 32'd0);
    checkOutput("zero_busy_idle", 32'(bus.load_busy_o), 32'd0);

    $display("[TB] oversize load clamped to depth");
    start_load(5'd20);
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (i == 10) start_load(5'd1);
      case (i % 4)
        0: applyStimulus(8'(i / 4));
        3: applyStimulus(8'hA0);
        default: applyStimulus(8'h00);
      endcase
      if (i == 4 * DEPTH - 2) checkOutput("clamp_not_early", 32'(bus.load_done_o), 32'd0);
    end
    checkOutput("clamp_done", 32'(bus.load_done_o), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(8'hFF);
    read_word(32'h0, "clamp_word0", 32'hA000_0000);
    read_word(32'h3C, "clamp_word15", 32'hA000_000F);
    read_word(32'h4, "clamp_word1", 32'hA000_0001);

    $display("[TB] reset mid-load");
    start_load(5'd2);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    bus.read_i  = 1'b1;
    bus.raddr_i = 32'h0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(bus.load_busy_o), 32'd0);
    checkOutput("midrst_rdata", bus.rdata_o, NOP);
    tick();
    checkOutput("midrst_done", 32'(bus.load_done_o), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("midrst_word0", bus.rdata_o, 32'h4433_2211);
    checkOutput("midrst_no_done", 32'(bus.load_done_o), 32'd0);
    bus.raddr_i = 32'h4;
    tick();
    checkOutput("midrst_word1", bus.rdata_o, 32'hA000_0001);
    bus.read_i = 1'b0;

    $display("[TB] address window");
`ifdef IMEM_ADDR_ERR_EN
    read_word(32'h40, "past_end_rdata", NOP);
    checkOutput("past_end_err", 32'(bus.err_o), 32'd1);
    read_word(32'h42, "misalign_rdata", NOP);
    checkOutput("misalign_err", 32'(bus.err_o), 32'd1);
    hold_val = NOP;
`else
    read_word(32'h40, "wrap_rdata", 32'h4433_2211);
    checkOutput("wrap_err", 32'(bus.err_o), 32'd0);
    read_word(32'h46, "low_bits_ignored", 32'hA000_0001);
    checkOutput("low_bits_err", 32'(bus.err_o), 32'd0);
    hold_val = 32'hA000_0001;
`endif
    bus.raddr_i = 32'h0;
    tick();
    checkOutput("idle_hold", bus.rdata_o, hold_val);
    read_word(32'h4, "valid_after_window", 32'hA000_0001);
    checkOutput("valid_err", 32'(bus.err_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
